// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered operand drive, SETTLE-cycle wait, then a held response.
module alu_share_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [N-1:0]     req_a0,
  input  logic [N-1:0]     req_b0,
  input  logic [2:0]       req_op0,
  input  logic [N-1:0]     req_a1,
  input  logic [N-1:0]     req_b1,
  input  logic [2:0]       req_op1,
  output logic [1:0]       req_ready,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [N-1:0]     alu_y,
  input  logic [3:0]       alu_nzcv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_y,
  output logic [3:0]       rsp_nzcv,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    grant     = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          state_nx  = EXEC;
        end
      end
      EXEC:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign hs   = |(req_valid & req_ready);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_nzcv   <= '0;
      ops_done   <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            alu_a      <= grant ? req_a1  : req_a0;
            alu_b      <= grant ? req_b1  : req_b0;
            alu_op     <= grant ? req_op1 : req_op0;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= SETTLE_LOAD;
          end
        end
        // Capture only in the last settle cycle so early ALU glitches are ignored.
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_y     <= alu_y;
            rsp_nzcv  <= alu_nzcv;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one SETTLE=1 instance for arbitration and
// handshake checks, one SETTLE=3/CNT_W=2 instance for settle and counter wrap.
module tb_alu_share_ctrl;

  typedef struct {
    logic [1:0] rv;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] op1;
    logic       id;
    logic [3:0] y;
    logic [3:0] nzcv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rv = 2'b00;
  logic [1:0] rv3 = 2'b00;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0] op0 = '0, op1 = '0;
  logic       rr = 1'b0;
  logic       rr3 = 1'b0;
  logic       corrupt = 1'b0;

  logic [1:0] rq, rq3;
  logic [3:0] alu_a, alu_b, alu_y, alu_nzcv, rsp_y, rsp_nzcv;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_id, busy;
  logic [7:0] ops_done;
  logic [3:0] alu_a3, alu_b3, alu_y3, alu_nzcv3, rsp_y3, rsp_nzcv3;
  logic [2:0] alu_op3;
  logic       rsp_valid3, rsp_id3, busy3;
  logic [1:0] ops_done3;
  logic [7:0] m3;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  // Reference ALU: op0 add, op1 sub (C = no borrow), others xor with C=V=0.
  function automatic logic [7:0] alu_model(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    logic [4:0] r;
    logic [3:0] y;
    logic       c, v;
    r = '0;
    case (op)
      3'd0: begin
        r = {1'b0, a} + {1'b0, b};
        y = r[3:0]; c = r[4];
        v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      3'd1: begin
        r = {1'b0, a} - {1'b0, b};
        y = r[3:0]; c = ~r[4];
        v = (a[3] != b[3]) && (y[3] != a[3]);
      end
      default: begin
        y = a ^ b; c = 1'b0; v = 1'b0;
      end
    endcase
    return {y[3], (y == 4'd0), c, v, y};
  endfunction

  assign {alu_nzcv, alu_y} = alu_model(alu_a, alu_b, alu_op);
  assign m3        = alu_model(alu_a3, alu_b3, alu_op3);
  assign alu_y3    = corrupt ? ~m3[3:0] : m3[3:0];
  assign alu_nzcv3 = corrupt ? ~m3[7:4] : m3[7:4];

  alu_share_ctrl #(.N(4), .SETTLE(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv),
    .req_a0(a0), .req_b0(b0), .req_op0(op0),
    .req_a1(a1), .req_b1(b1), .req_op1(op1),
    .req_ready(rq), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_nzcv(alu_nzcv),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_nzcv(rsp_nzcv), .busy(busy), .ops_done(ops_done)
  );

  alu_share_ctrl #(.N(4), .SETTLE(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3),
    .req_a0(a0), .req_b0(b0), .req_op0(op0),
    .req_a1(a1), .req_b1(b1), .req_op1(op1),
    .req_ready(rq3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_y(alu_y3), .alu_nzcv(alu_nzcv3),
    .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_id(rsp_id3),
    .rsp_y(rsp_y3), .rsp_nzcv(rsp_nzcv3), .busy(busy3), .ops_done(ops_done3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the SETTLE=1 instance idle; returns at a negedge, idle again.
  task automatic applyStimulus(input vec_t v);
    int n;
    rv = v.rv; a0 = v.a0; b0 = v.b0; op0 = v.op0;
    a1 = v.a1; b1 = v.b1; op1 = v.op1; rr = 1'b1;
    #1;
    checkOutput("req_ready", rq, v.id ? 2'b10 : 2'b01);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checkOutput("operands", {alu_a, alu_b, alu_op},
                    v.id ? {v.a1, v.b1, v.op1} : {v.a0, v.b0, v.op0});
        checkOutput("busy_exec", busy, 1'b1);
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      end
    end while (!rsp_valid && n < 20);
    checkOutput("latency", n, 2);
    checkOutput("rsp_id", rsp_id, v.id);
    checkOutput("rsp_y", rsp_y, v.y);
    checkOutput("rsp_nzcv", rsp_nzcv, v.nzcv);
    @(posedge clk);
    @(negedge clk);
    done_count++;
    checkOutput("ops_done", ops_done, done_count);
    checkOutput("idle_after_accept", {busy, rsp_valid}, 2'b00);
  endtask

  vec_t vecs[8];
  logic [1:0] wrap_exp[4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  saw_valid;
    vecs[0] = '{2'b11, 4'd8,  4'd15, 3'd1, 4'd0, 4'd0, 3'd0, 1'b0, 4'd9,  4'b1000};
    vecs[1] = '{2'b11, 4'd8,  4'd15, 3'd1, 4'd0, 4'd0, 3'd0, 1'b1, 4'd0,  4'b0100};
    vecs[2] = '{2'b11, 4'd8,  4'd15, 3'd1, 4'd0, 4'd0, 3'd0, 1'b0, 4'd9,  4'b1000};
    vecs[3] = '{2'b01, 4'd15, 4'd15, 3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd14, 4'b1010};
    vecs[4] = '{2'b10, 4'd0,  4'd0,  3'd0, 4'd7, 4'd1, 3'd1, 1'b1, 4'd6,  4'b0010};
    vecs[5] = '{2'b01, 4'd7,  4'd1,  3'd0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd8,  4'b1001};
    vecs[6] = '{2'b10, 4'd0,  4'd0,  3'd0, 4'd3, 4'd5, 3'd1, 1'b1, 4'd14, 4'b1000};
    vecs[7] = '{2'b01, 4'd12, 4'd10, 3'd7, 4'd0, 4'd0, 3'd0, 1'b0, 4'd6,  4'b0000};
    wrap_exp = '{2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {rsp_valid, rsp_id, rsp_y, rsp_nzcv, busy, alu_a, alu_b, alu_op},
                '0);
    checkOutput("reset_ops_done", ops_done, 8'd0);
    checkOutput("reset_ready", rq, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of EXEC discards the request
    rv = 2'b01; a0 = 4'd15; b0 = 4'd15; op0 = 3'd0; rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_before_reset", busy, 1'b1);
    rv = 2'b00;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {busy, rsp_valid, alu_a, ops_done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || busy) saw_valid = 1'b1;
    end
    checkOutput("no_stale_rsp", saw_valid, 1'b0);

    // Table: contention alternation, single requests, flags, opcode pass-through
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    rv = 2'b00;

    // Backpressure: response held, no new grant while RESP
    a0 = 4'd3; b0 = 4'd4; op0 = 3'd0; rv = 2'b01; rr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rv = 2'b00;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_rsp_seen", rsp_valid, 1'b1);
    rv = 2'b11; a0 = 4'd9; a1 = 4'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_hold", {rsp_valid, rsp_id, rsp_y, rsp_nzcv, rq, alu_a},
                  {1'b1, 1'b0, 4'd7, 4'b0000, 2'b00, 4'd3});
    end
    rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release_idle", {busy, rsp_valid, alu_a}, {1'b0, 1'b0, 4'd3});
    rv = 2'b00;
    done_count++;
    checkOutput("bp_ops_done", ops_done, done_count);

    // SETTLE=3: operands held, only final-cycle ALU value captured
    @(negedge clk);
    rv3 = 2'b01; a0 = 4'd5; b0 = 4'd6; op0 = 3'd0; rr3 = 1'b0; corrupt = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 3) checkOutput("settle_hold", {alu_a3, alu_b3, alu_op3, rsp_valid3},
                              {4'd5, 4'd6, 3'd0, 1'b0});
      if (n == 1) begin rv3 = 2'b00; a0 = 4'd9; end
      if (n == 2) corrupt = 1'b0;
    end while (!rsp_valid3 && n < 20);
    checkOutput("settle_latency", n, 4);
    checkOutput("settle_rsp", {rsp_id3, rsp_y3, rsp_nzcv3}, {1'b0, 4'd11, 4'b1001});
    rr3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrap_ops_done", ops_done3, 2'd1);

    // CNT_W=2 counter wrap
    for (int k = 0; k < 4; k++) begin
      rv3 = 2'b10; a1 = 4'd1; b1 = 4'd1; op1 = 3'd0;
      @(posedge clk);
      @(negedge clk);
      rv3 = 2'b00;
      n = 0;
      while (!rsp_valid3 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("wrap_rsp", {rsp_valid3, rsp_id3, rsp_y3}, {1'b1, 1'b1, 4'd2});
      @(posedge clk);
      @(negedge clk);
      checkOutput("wrap_ops_done", ops_done3, wrap_exp[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
